midi_voice_alloc: RTL

Polyphonic voice allocator between the MIDI event source and a bank of per-voice oscillators and envelopes. It accepts 3-byte channel-0 MIDI events over a valid/ready handshake and decodes NOTE_ON and NOTE_OFF. Each note is assigned to one of NUM_VOICES voices: retrigger of the same note first, then a free voice, then stealing the least-recently-assigned voice. It drives per-voice note, velocity, gate and a one-cycle trigger pulse that starts the voice envelope.

---
 rtl/midi_voice_alloc.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/midi_voice_alloc.sv
// Channel-0 NOTE_ON/NOTE_OFF voice allocator: retrigger, then free voice, then LRU steal.
// Stealing is enabled by defining VOICE_ALLOC_STEAL_EN; one note event per NUM_VOICES+2 cycles.
module midi_voice_alloc #(
  parameter int NUM_VOICES = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    event_valid_in,
  input  logic [23:0]             event_in,
  output logic                    event_ready_out,
  output logic [8*NUM_VOICES-1:0] voice_note_out,
  output logic [8*NUM_VOICES-1:0] voice_vel_out,
  output logic [NUM_VOICES-1:0]   voice_gate_out,
  output logic [NUM_VOICES-1:0]   voice_trig_out,
  output logic                    steal_out
);
  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
  state_t state, state_nxt;

  logic [7:0]            note [NUM_VOICES];
  logic [7:0]            vel  [NUM_VOICES];
  logic [IW-1:0]         rank [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate;
  logic [NUM_VOICES-1:0] trig;

  logic [7:0]            ev_note;
  logic [7:0]            ev_vel;
  logic                  ev_on;
  logic [IW-1:0]         scan_idx;
  logic                  match_found;
  logic                  free_found;
  logic [IW-1:0]         match_idx;
  logic [IW-1:0]         free_idx;
  logic [IW-1:0]         oldest_idx;
  logic [NUM_VOICES-1:0] off_mask;

  logic                  xfer;
  logic                  in_on;
  logic                  in_off;
  logic [IW-1:0]         tgt;
  logic                  do_assign;
`ifdef VOICE_ALLOC_STEAL_EN
  logic                  do_steal;
  logic                  steal;
`endif

  assign xfer   = event_valid_in && event_ready_out;
  assign in_on  = (event_in[23:16] == 8'h90) && (event_in[7:0] != 8'h00);
  assign in_off = (event_in[23:16] == 8'h80) ||
                  ((event_in[23:16] == 8'h90) && (event_in[7:0] == 8'h00));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    event_ready_out = 1'b0;
    case (state)
      IDLE: begin
        event_ready_out = 1'b1;
        if (xfer && (in_on || in_off)) state_nxt = SCAN;
      end
      SCAN:    if (scan_idx == LAST) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Target priority: retrigger of a held note, then first free voice, then the oldest.
  always_comb begin
    tgt       = oldest_idx;
    do_assign = 1'b0;
`ifdef VOICE_ALLOC_STEAL_EN
    do_steal  = 1'b0;
`endif
    if (match_found) begin
      tgt       = match_idx;
      do_assign = 1'b1;
    end else if (free_found) begin
      tgt       = free_idx;
      do_assign = 1'b1;
    end
`ifdef VOICE_ALLOC_STEAL_EN
    else begin
      do_assign = 1'b1;
      do_steal  = gate[oldest_idx];
    end
`endif
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        note[i] <= 8'h00;
        vel[i]  <= 8'h00;
        rank[i] <= IW'(i);
      end
      gate        <= '0;
      trig        <= '0;
      ev_note     <= 8'h00;
      ev_vel      <= 8'h00;
      ev_on       <= 1'b0;
      scan_idx    <= '0;
      match_found <= 1'b0;
      free_found  <= 1'b0;
      match_idx   <= '0;
      free_idx    <= '0;
      oldest_idx  <= '0;
      off_mask    <= '0;
    end else begin
      trig <= '0;
      case (state)
        IDLE: begin
          if (xfer) begin
            ev_note     <= event_in[15:8];
            ev_vel      <= event_in[7:0];
            ev_on       <= in_on;
            scan_idx    <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            off_mask    <= '0;
          end
        end
        SCAN: begin
          scan_idx <= scan_idx + 1'b1;
          if (ev_on) begin
            if (!match_found && gate[scan_idx] && (note[scan_idx] == ev_note)) begin
              match_found <= 1'b1;
              match_idx   <= scan_idx;
            end
            if (!free_found && !gate[scan_idx]) begin
              free_found <= 1'b1;
              free_idx   <= scan_idx;
            end
            if (rank[scan_idx] == LAST) oldest_idx <= scan_idx;
          end else begin
            off_mask[scan_idx] <= gate[scan_idx] && (note[scan_idx] == ev_note);
          end
        end
        COMMIT: begin
          if (ev_on) begin
            if (do_assign) begin
              // Voices more recent than the target age by one; the target becomes newest.
              for (int i = 0; i < NUM_VOICES; i++) begin
                if (rank[i] < rank[tgt]) rank[i] <= rank[i] + 1'b1;
              end
              rank[tgt] <= '0;
              note[tgt] <= ev_note;
              vel[tgt]  <= ev_vel;
              gate[tgt] <= 1'b1;
              trig[tgt] <= 1'b1;
            end
          end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (off_mask[i]) begin
                gate[i] <= 1'b0;
                vel[i]  <= ev_vel;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef VOICE_ALLOC_STEAL_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) steal <= 1'b0;
    else        steal <= (state == COMMIT) && ev_on && do_steal;
  end
  assign steal_out = steal;
`else
  assign steal_out = 1'b0;
`endif

  always_comb begin
    voice_note_out = '0;
    voice_vel_out  = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_note_out[8*i +: 8] = note[i];
      voice_vel_out[8*i +: 8]  = vel[i];
    end
  end

  assign voice_gate_out = gate;
  assign voice_trig_out = trig;

endmodule
